// File: rtl/alu_drv_pkg.sv
// rtl/alu_drv_pkg.sv - shared types, flag indices and command legality rules for alu_req_driver
// Contents: driver state enum, response flag bit positions, legal-command masks
// and cmd_is_legal(), used by alu_cmd_legal_chk when ALU_DRV_CMD_CHECK_EN is defined.
package alu_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } drv_state_e;

    // Bit positions inside rsp_flags = {ERR,L,E,G,OFLOW,COUT}
    localparam int FLAG_COUT  = 0;
    localparam int FLAG_OFLOW = 1;
    localparam int FLAG_G     = 2;
    localparam int FLAG_E     = 3;
    localparam int FLAG_L     = 4;
    localparam int FLAG_ERR   = 5;
    localparam int NUM_FLAGS  = 6;

    // Response flags returned for a request rejected by the legality check
    localparam logic [NUM_FLAGS-1:0] ILLEGAL_FLAGS = 6'b100000;

    // One bit per command code 0..15; bit n set means command n is legal
    localparam logic [15:0] LEGAL_ARITH_INV11 = 16'h1F0F;  // 0-3, 8-12
    localparam logic [15:0] LEGAL_ARITH_INV01 = 16'h0030;  // 4, 5
    localparam logic [15:0] LEGAL_ARITH_INV10 = 16'h00C0;  // 6, 7
    localparam logic [15:0] LEGAL_LOGIC_INV11 = 16'h303F;  // 0-5, 12, 13
    localparam logic [15:0] LEGAL_LOGIC_INV1X = 16'h0340;  // 6, 8, 9 (INV 01 or 10)

    function automatic logic cmd_is_legal(input logic mode, input logic [1:0] inv,
                                          input logic [31:0] cmd);
        logic [15:0] mask;
        mask = '0;
        if (mode) begin
            case (inv)
                2'b11:   mask = LEGAL_ARITH_INV11;
                2'b01:   mask = LEGAL_ARITH_INV01;
                2'b10:   mask = LEGAL_ARITH_INV10;
                default: mask = '0;
            endcase
        end else begin
            case (inv)
                2'b11:        mask = LEGAL_LOGIC_INV11;
                2'b01, 2'b10: mask = LEGAL_LOGIC_INV1X;
                default:      mask = '0;
            endcase
        end
        return (cmd < 32'd16) && mask[cmd[3:0]];
    endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// rtl/alu_req_driver_if.sv - request, ALU pin and response bundle for alu_req_driver
// Groups: request channel (req_*), ALU drive pins (opa..in_valid), ALU return
// (alu_*), response channel (rsp_*) and txn_cnt.
// Modports: slave = the driver block (slave of the request channel, owner of the
// ALU pins); master = command source plus ALU.
interface alu_req_driver_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int CNT_WIDTH = 16
);
    logic                   req_valid;
    logic                   req_ready;
    logic [WIDTH-1:0]       req_opa;
    logic [WIDTH-1:0]       req_opb;
    logic [CMD_WIDTH-1:0]   req_cmd;
    logic                   req_mode;
    logic                   req_cin;
    logic [1:0]             req_inv;

    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [CMD_WIDTH-1:0]   cmd;
    logic                   mode;
    logic                   cin;
    logic                   ce;
    logic [1:0]             in_valid;

    logic [2*WIDTH-1:0]     alu_res;
    logic                   alu_cout;
    logic                   alu_oflow;
    logic                   alu_g;
    logic                   alu_e;
    logic                   alu_l;
    logic                   alu_err;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [2*WIDTH-1:0]     rsp_res;
    logic [5:0]             rsp_flags;
    logic [CNT_WIDTH-1:0]   txn_cnt;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inv,
        output req_ready,
        output opa, opb, cmd, mode, cin, ce, in_valid,
        input  alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
        output rsp_valid, rsp_res, rsp_flags, txn_cnt,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inv,
        input  req_ready,
        input  opa, opb, cmd, mode, cin, ce, in_valid,
        output alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
        input  rsp_valid, rsp_res, rsp_flags, txn_cnt,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_legal_chk.sv
// rtl/alu_cmd_legal_chk.sv - combinational request legality check for alu_req_driver
// Ports: mode, inv, cmd (request fields) in; legal out (1 = may be issued to the ALU).
module alu_cmd_legal_chk
    import alu_drv_pkg::*;
#(
    parameter int CMD_WIDTH = 4
) (
    input  logic                 mode,
    input  logic [1:0]           inv,
    input  logic [CMD_WIDTH-1:0] cmd,
    output logic                 legal
);
    assign legal = cmd_is_legal(mode, inv, 32'(cmd));
endmodule

// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - ALU request front end: accept request, drive CE for LATENCY edges, return result
// Ports: clk, rst_n (async, active low); bus (alu_req_driver_if.slave) carrying the
// request channel, ALU pins, ALU outputs, response channel and txn_cnt.
// Option: ALU_DRV_CMD_CHECK_EN rejects illegal requests at accept with flags 6'b100000.
module alu_req_driver
    import alu_drv_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int LATENCY   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_driver_if.slave  bus
);
    localparam int LAT_W = $clog2(LATENCY + 1);

    drv_state_e             state_q, state_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]       opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic                   mode_q, mode_d, cin_q, cin_d;
    logic [1:0]             inv_q, inv_d, in_valid_q, in_valid_d;
    logic                   ce_q, ce_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]     rsp_res_q, rsp_res_d;
    logic [NUM_FLAGS-1:0]   rsp_flags_q, rsp_flags_d;
    logic [CNT_WIDTH-1:0]   txn_cnt_q, txn_cnt_d;
    logic                   req_legal;

`ifdef ALU_DRV_CMD_CHECK_EN
    alu_cmd_legal_chk #(.CMD_WIDTH(CMD_WIDTH)) u_legal_chk (
        .mode  (bus.req_mode),
        .inv   (bus.req_inv),
        .cmd   (bus.req_cmd),
        .legal (req_legal)
    );
`else
    assign req_legal = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        inv_d       = inv_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        txn_cnt_d   = txn_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_ready_q && bus.req_valid) begin
                    inv_d     = bus.req_inv;
                    lat_cnt_d = '0;
                    if (req_legal) begin
                        // Pins only move for requests that will actually reach the ALU
                        opa_d   = bus.req_opa;
                        opb_d   = bus.req_opb;
                        cmd_d   = bus.req_cmd;
                        mode_d  = bus.req_mode;
                        cin_d   = bus.req_cin;
                        state_d = ST_ISSUE;
                    end else begin
                        rsp_res_d   = '0;
                        rsp_flags_d = ILLEGAL_FLAGS;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                // lat_cnt counts CE-high edges already taken; the LATENCY-th one ends ISSUE
                if (lat_cnt_q == LAT_W'(LATENCY - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_res_d              = bus.alu_res;
                rsp_flags_d[FLAG_COUT]  = bus.alu_cout;
                rsp_flags_d[FLAG_OFLOW] = bus.alu_oflow;
                rsp_flags_d[FLAG_G]     = bus.alu_g;
                rsp_flags_d[FLAG_E]     = bus.alu_e;
                rsp_flags_d[FLAG_L]     = bus.alu_l;
                rsp_flags_d[FLAG_ERR]   = bus.alu_err;
                state_d                 = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    txn_cnt_d = txn_cnt_q + CNT_WIDTH'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and CE outputs are registered copies of the next state
        req_ready_d = (state_d == ST_IDLE);
        ce_d        = (state_d == ST_ISSUE);
        in_valid_d  = ce_d ? inv_d : 2'b00;
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            inv_q       <= 2'b00;
            in_valid_q  <= 2'b00;
            ce_q        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            inv_q       <= inv_d;
            in_valid_q  <= in_valid_d;
            ce_q        <= ce_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.cmd       = cmd_q;
    assign bus.mode      = mode_q;
    assign bus.cin       = cin_q;
    assign bus.ce        = ce_q;
    assign bus.in_valid  = in_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - self-checking bench for alu_req_driver
module tb_alu_req_driver;
    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int LAT   = 2;
    localparam int CNTW  = 4;
    localparam int CNT_MOD = 1 << CNTW;
`ifdef ALU_DRV_CMD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_req_driver_if #(.WIDTH(W), .CMD_WIDTH(CW), .CNT_WIDTH(CNTW)) bus ();

    alu_req_driver #(.WIDTH(W), .CMD_WIDTH(CW), .LATENCY(LAT), .CNT_WIDTH(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [23:0] last_pins = '0;   // {opa,opb,cmd,mode,cin}
    time last_acc_t = 0;

    // Stand-in ALU: result valid only after exactly LAT CE-high edges, inverted otherwise
    function automatic logic [21:0] alu_fn(input logic mode, input logic cin, input logic [1:0] inv,
                                           input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        logic [15:0] res;
        logic [5:0] fl;
        if (mode && cmd == 4'd0) begin
            sum = a + b + 9'(cin);
            res = {7'd0, sum};
            fl  = {4'b0000, (a[7] == b[7]) && (sum[7] != a[7]), sum[8]};
        end else if (mode && cmd == 4'd8) begin
            res = 16'h0000;
            fl  = {1'b0, a < b, a == b, a > b, 2'b00};
        end else begin
            res = {a ^ b, 8'(a + b)} ^ {12'd0, cmd};
            fl  = {inv == 2'b00, a[0], b[0], mode, cin, ^a};
        end
        return {fl, res};
    endfunction

    function automatic bit rule_legal(input logic mode, input logic [1:0] inv, input int cmd);
        if (inv == 2'b00) return 1'b0;
        if (mode) begin
            if (inv == 2'b11) return (cmd <= 3) || (cmd >= 8 && cmd <= 12);
            if (inv == 2'b01) return (cmd == 4) || (cmd == 5);
            return (cmd == 6) || (cmd == 7);
        end
        if (inv == 2'b11) return (cmd <= 5) || (cmd == 12) || (cmd == 13);
        return (cmd == 6) || (cmd == 8) || (cmd == 9);
    endfunction

    int alu_edges = 0;
    logic [21:0] alu_out = '0;
    always @(posedge clk) begin
        if (!bus.ce) begin
            alu_edges <= 0;
        end else begin
            alu_edges <= alu_edges + 1;
            if (alu_edges + 1 == LAT)
                alu_out <= alu_fn(bus.mode, bus.cin, bus.in_valid, bus.cmd, bus.opa, bus.opb);
            else
                alu_out <= ~alu_fn(bus.mode, bus.cin, bus.in_valid, bus.cmd, bus.opa, bus.opb);
        end
    end
    assign bus.alu_res = alu_out[15:0];
    assign {bus.alu_err, bus.alu_l, bus.alu_e, bus.alu_g, bus.alu_oflow, bus.alu_cout} = alu_out[21:16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic mode, input logic cin, input logic [1:0] inv, input logic [3:0] cmd,
                          input logic [7:0] a, input logic [7:0] b, input logic [15:0] er,
                          input logic [5:0] ef, input int bp, input string tag);
        int guard, k, ce_cycles;
        bit legal;
        logic [15:0] xr;
        logic [5:0] xf;
        legal = CHECK_EN ? rule_legal(mode, inv, int'(cmd)) : 1'b1;
        xr = legal ? er : 16'h0000;
        xf = legal ? ef : 6'b100000;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'(1));
        if (bp > 0) bus.rsp_ready = 1'b0;
        bus.req_mode = mode; bus.req_cin = cin; bus.req_inv = inv;
        bus.req_cmd = cmd; bus.req_opa = a; bus.req_opb = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        last_acc_t = $time;
        #1;
        // Keep valid high with junk fields: must neither be accepted nor leak onto the pins
        bus.req_opa = 8'($urandom); bus.req_opb = 8'($urandom);
        bus.req_cmd = 4'($urandom); bus.req_inv = 2'($urandom);
        bus.req_mode = 1'($urandom); bus.req_cin = 1'($urandom);
        k = 0;
        ce_cycles = 0;
        do begin
            @(negedge clk);
            k++;
            if (bus.ce) begin
                ce_cycles++;
                chk({tag, " issue pins"}, 64'({bus.opa, bus.opb, bus.cmd, bus.mode, bus.cin, bus.in_valid}),
                    64'({a, b, cmd, mode, cin, inv}));
            end
        end while (!bus.rsp_valid && k < 20);
        chk({tag, " rsp latency"}, 64'(k), legal ? 64'(LAT + 2) : 64'(1));
        chk({tag, " ce cycles"}, 64'(ce_cycles), legal ? 64'(LAT) : 64'(0));
        chk({tag, " rsp_res"}, 64'(bus.rsp_res), 64'(xr));
        chk({tag, " rsp_flags"}, 64'(bus.rsp_flags), 64'(xf));
        chk({tag, " busy req_ready"}, 64'(bus.req_ready), 64'(0));
        for (int i = 1; i < bp; i++) begin
            @(negedge clk);
            chk({tag, " backpressure hold"},
                64'({bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.req_ready, bus.txn_cnt}),
                64'({1'b1, xr, xf, 1'b0, 4'(exp_cnt)}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        if (legal) last_pins = {a, b, cmd, mode, cin};
        chk({tag, " rsp_valid drop"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, " txn_cnt"}, 64'(bus.txn_cnt), 64'(exp_cnt));
        chk({tag, " idle pins"}, 64'({bus.ce, bus.in_valid, bus.opa, bus.opb, bus.cmd, bus.mode, bus.cin}),
            64'({3'b000, last_pins}));
    endtask

    typedef struct {
        logic       mode;
        logic       cin;
        logic [1:0] inv;
        logic [3:0] cmd;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [15:0] exp_res;
        logic [5:0]  exp_flags;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic m, c;
        logic [1:0] iv;
        logic [3:0] cm;
        logic [7:0] a, b;
        logic [21:0] ref_out;
        time prev_t;

        vecs[0] = '{1'b1, 1'b0, 2'b11, 4'd0, 8'hF0, 8'h20, 16'h0110, 6'b000001};  // add, carry out
        vecs[1] = '{1'b1, 1'b0, 2'b11, 4'd8, 8'h05, 8'h05, 16'h0000, 6'b001000};  // compare equal
        vecs[2] = '{1'b1, 1'b0, 2'b11, 4'd0, 8'h70, 8'h20, 16'h0090, 6'b000010};  // signed overflow
        vecs[3] = '{1'b1, 1'b1, 2'b11, 4'd0, 8'hFF, 8'h00, 16'h0100, 6'b000001};  // carry-in ripple
        vecs[4] = '{1'b1, 1'b0, 2'b11, 4'd8, 8'h09, 8'h03, 16'h0000, 6'b000100};  // greater
        vecs[5] = '{1'b1, 1'b0, 2'b11, 4'd8, 8'h02, 8'h07, 16'h0000, 6'b010000};  // less
        vecs[6] = '{1'b0, 1'b0, 2'b11, 4'd1, 8'h3C, 8'h0F, 16'h334A, 6'b001000};  // logic op passthrough

        bus.req_valid = 1'b0; bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
        bus.req_mode = 1'b0; bus.req_cin = 1'b0; bus.req_inv = 2'b00; bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset req_ready", 64'(bus.req_ready), 64'(0));
        chk("reset ce/in_valid", 64'({bus.ce, bus.in_valid}), 64'(0));
        chk("reset rsp", 64'({bus.rsp_valid, bus.rsp_res, bus.rsp_flags}), 64'(0));
        chk("reset txn_cnt", 64'(bus.txn_cnt), 64'(0));
        chk("reset pins", 64'({bus.opa, bus.opb, bus.cmd, bus.mode, bus.cin}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready after release", 64'(bus.req_ready), 64'(1));

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].mode, vecs[i].cin, vecs[i].inv, vecs[i].cmd, vecs[i].opa, vecs[i].opb,
                   vecs[i].exp_res, vecs[i].exp_flags, 0, $sformatf("vec%0d", i));

        // Response back-pressure: ready low for 3 RESP cycles
        do_txn(1'b1, 1'b0, 2'b11, 4'd0, 8'h12, 8'h34, 16'h0046, 6'b000000, 3, "backpressure");

        if (CHECK_EN)
            do_txn(1'b1, 1'b0, 2'b01, 4'd0, 8'hAA, 8'h55, 16'h0000, 6'b000000, 0, "illegal");

        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom); c = 1'($urandom); iv = 2'($urandom);
            cm = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            ref_out = alu_fn(m, c, iv, cm, a, b);
            do_txn(m, c, iv, cm, a, b, ref_out[15:0], ref_out[21:16],
                   int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        // Reset while CE is high: transaction dropped, everything cleared
        bus.req_mode = 1'b1; bus.req_cin = 1'b0; bus.req_inv = 2'b11;
        bus.req_cmd = 4'd0; bus.req_opa = 8'h11; bus.req_opb = 8'h22;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midreset ce before", 64'(bus.ce), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midreset ce/in_valid", 64'({bus.ce, bus.in_valid}), 64'(0));
        chk("midreset rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midreset txn_cnt", 64'(bus.txn_cnt), 64'(0));
        chk("midreset req_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        last_pins = '0;

        // Back-to-back legal requests: counter wraps, period LAT+3 cycles
        for (int i = 0; i < 16; i++) begin
            cm = 4'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            ref_out = alu_fn(1'b1, c, 2'b11, cm, a, b);
            prev_t = last_acc_t;
            do_txn(1'b1, c, 2'b11, cm, a, b, ref_out[15:0], ref_out[21:16], 0, $sformatf("wrap%0d", i));
            if (i > 0) chk("issue period", 64'(last_acc_t - prev_t), 64'((LAT + 3) * 10));
            if (i == 14) chk("txn_cnt at max", 64'(bus.txn_cnt), 64'(15));
            if (i == 15) chk("txn_cnt wrapped", 64'(bus.txn_cnt), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
